// File: rtl/tsc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tsc_pkg
//  Description : Shared constants and reader state encoding for the TSC ring
//                buffer drain path.
//  Revision    : 1.0 - initial release
// ============================================================================
package tsc_pkg;

    localparam int TSC_DATA_W = 8;
    localparam int TSC_ADDR_W = 4;
    localparam int TSC_DEPTH  = 16;

    // Reader fetch sequence: wait for data, strobe the read port, capture the
    // returned word, then present it until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } tsc_rd_state_t;

endpackage
`default_nettype wire

// File: rtl/tsc_ring_level.sv
`default_nettype none
// ============================================================================
//  Module      : tsc_ring_level
//  Description : Occupancy and read-pointer bookkeeping for the TSC ring.
//                Counts unread entries from write pulses and read issues,
//                drops the oldest entry on overrun and keeps a sticky flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tsc_ring_level #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_seen,
    input  logic              issue,
    input  logic              clear_ovf,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              overflow
);

    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0]   r_level;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_overflow;
    logic              w_full;
    logic              w_drop;
    logic              w_adv;
    logic [ADDR_W:0]   w_level_nxt;

    // A write into a full ring with no read in flight overwrites the oldest
    // entry, so the pointer skips past it instead of the level growing.
    assign w_full = (r_level == C_DEPTH);
    assign w_drop = wr_seen && !issue && w_full;
    assign w_adv  = issue || w_drop;

    // Net occupancy change for this cycle; simultaneous write and issue cancel.
    always_comb begin
        w_level_nxt = r_level;
        if (wr_seen && !issue && !w_full) begin
            w_level_nxt = r_level + 1'b1;
        end else if (issue && !wr_seen) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Level, pointer and sticky overrun flag; a new overrun beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level    <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            if (w_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign level    = r_level;
    assign rd_ptr   = r_rd_ptr;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/tsc_ring_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tsc_ring_reader
//  Description : Drain side of the TSC ring buffer. Fetches unread entries
//                oldest-first through the synchronous read port and presents
//                them on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tsc_ring_reader
    import tsc_pkg::*;
#(
    parameter int DATA_W = TSC_DATA_W,
    parameter int ADDR_W = TSC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_seen,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              clear_ovf
);

    tsc_rd_state_t     r_state;
    tsc_rd_state_t     w_state_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W:0]   w_level;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic              w_issue;
    logic              w_handshake;
    logic              w_more;

    assign w_issue     = (r_state == READ);
    assign w_handshake = (r_state == HOLD) && out_ready;
    // No issue happens in HOLD, so the post-update level is non-zero exactly
    // when entries remain or a write arrives this cycle.
    assign w_more      = (w_level != '0) || wr_seen;

    tsc_ring_level #(
        .ADDR_W (ADDR_W)
    ) u_level (
        .clk       (clk),
        .reset     (reset),
        .wr_seen   (wr_seen),
        .issue     (w_issue),
        .clear_ovf (clear_ovf),
        .level     (w_level),
        .rd_ptr    (w_rd_ptr),
        .overflow  (overflow)
    );

    // Reader state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode for the fetch sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_level != '0) w_state_nxt = READ;
            READ:    w_state_nxt = WAIT;
            WAIT:    w_state_nxt = HOLD;
            HOLD:    if (w_handshake) w_state_nxt = w_more ? READ : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output entry is loaded only from the read port in WAIT, so it stays put
    // while held regardless of later writes or overruns.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data <= '0;
        end else if (r_state == WAIT) begin
            r_out_data <= rd_data;
        end
    end

    assign rd_en     = w_issue;
    assign rd_addr   = w_rd_ptr;
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign level     = w_level;

endmodule
`default_nettype wire

// File: tb/tb_tsc_ring_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tsc_ring_reader
//  Description : Directed self-checking bench for tsc_ring_reader with a
//                behavioural 16x8 ring buffer on the read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tsc_ring_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_seen = 1'b0;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       overflow;
    logic       clear_ovf = 1'b0;

    logic [7:0] wdata = 8'h00;
    logic [3:0] waddr;
    logic [7:0] mem [0:15];

    logic [3:0] mon_addr [$];
    logic [7:0] mon_data [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tsc_ring_reader #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_seen   (wr_seen),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    // Ring buffer model: sequential write address, 1-cycle synchronous read.
    always @(posedge clk) begin
        if (reset) begin
            waddr <= 4'd0;
        end else if (wr_seen) begin
            mem[waddr] <= wdata;
            waddr      <= waddr + 4'd1;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Record issued addresses and accepted entries.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) mon_addr.push_back(rd_addr);
            if (out_valid && out_ready) mon_data.push_back(out_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_seen = 1'b0;
        clear_ovf = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic write1(input logic [7:0] v);
        wdata = v;
        wr_seen = 1'b1;
        tick();
        wr_seen = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        wait_valid(tag);
        check(tag, {24'd0, out_data}, {24'd0, exp});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        do_reset();
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);

        // Single entry: latency write -> out_valid is 4 cycles
        out_ready = 1'b1;
        write1(8'hFF);
        check("s_level_c1", {27'd0, level}, 32'd1);
        check("s_rd_en_c1", {31'd0, rd_en}, 32'd0);
        tick();
        check("s_rd_en_c2", {31'd0, rd_en}, 32'd1);
        check("s_rd_addr_c2", {28'd0, rd_addr}, 32'd0);
        tick();
        check("s_valid_c3", {31'd0, out_valid}, 32'd0);
        tick();
        check("s_valid_c4", {31'd0, out_valid}, 32'd1);
        check("s_data_c4", {24'd0, out_data}, 32'hFF);
        check("s_level_c4", {27'd0, level}, 32'd0);
        tick();
        check("s_valid_c5", {31'd0, out_valid}, 32'd0);
        check("s_rd_en_c5", {31'd0, rd_en}, 32'd0);

        // Backpressure: first entry held stable, rest come out in order
        do_reset();
        out_ready = 1'b0;
        wdata = 8'h11; wr_seen = 1'b1; tick();
        wdata = 8'h22; tick();
        wdata = 8'h33; tick();
        wr_seen = 1'b0;
        wait_valid("bp_first");
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_data", {24'd0, out_data}, 32'h11);
        end
        check("bp_level", {27'd0, level}, 32'd2);
        pop("bp_0", 8'h11);
        pop("bp_1", 8'h22);
        pop("bp_2", 8'h33);
        check("bp_level_end", {27'd0, level}, 32'd0);

        // Wrap: 20 writes paced one per 4 cycles
        do_reset();
        out_ready = 1'b1;
        mon_addr.delete();
        mon_data.delete();
        for (int i = 0; i < 20; i++) begin
            write1(8'h80 + 8'(i));
            tick(); tick(); tick();
        end
        for (int i = 0; i < 6; i++) tick();
        out_ready = 1'b0;
        check("wrap_n_addr", mon_addr.size(), 32'd20);
        check("wrap_n_data", mon_data.size(), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < mon_addr.size()) check("wrap_addr", {28'd0, mon_addr[i]}, 32'(i % 16));
            if (i < mon_data.size()) check("wrap_data", {24'd0, mon_data[i]}, 32'(8'h80 + 8'(i)));
        end
        check("wrap_ovf", {31'd0, overflow}, 32'd0);

        // Overrun with the first entry already issued: 18 back-to-back writes;
        // addr0 fetched at cycle 2, the 18th write drops addr1's entry.
        do_reset();
        out_ready = 1'b0;
        wr_seen = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wdata = 8'h40 + 8'(i);
            tick();
        end
        wr_seen = 1'b0;
        check("ovr1_level_full", {27'd0, level}, 32'd16);
        check("ovr1_ovf_pre", {31'd0, overflow}, 32'd0);
        write1(8'h51);
        check("ovr1_level", {27'd0, level}, 32'd16);
        check("ovr1_ovf", {31'd0, overflow}, 32'd1);
        pop("ovr1_first", 8'h40);
        pop("ovr1_second", 8'h42);

        // Overrun before any issue of the 17 writes: reader parked in HOLD.
        do_reset();
        out_ready = 1'b0;
        write1(8'hA5);
        wait_valid("ovr2_park");
        wr_seen = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'h60 + 8'(i);
            tick();
        end
        wr_seen = 1'b0;
        check("ovr2_level_full", {27'd0, level}, 32'd16);
        check("ovr2_ovf_pre", {31'd0, overflow}, 32'd0);
        clear_ovf = 1'b1;
        write1(8'h70);
        check("ovr2_set_wins", {31'd0, overflow}, 32'd1);
        check("ovr2_level", {27'd0, level}, 32'd16);
        tick();
        clear_ovf = 1'b0;
        check("ovr2_cleared", {31'd0, overflow}, 32'd0);
        pop("ovr2_first", 8'hA5);
        pop("ovr2_second", 8'h61);

        // Reset while in WAIT with level 5
        do_reset();
        out_ready = 1'b0;
        write1(8'h01);
        wait_valid("rw_park");
        wr_seen = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wdata = 8'hC0 + 8'(i);
            tick();
        end
        wr_seen = 1'b0;
        check("rw_level6", {27'd0, level}, 32'd6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rw_read", {31'd0, rd_en}, 32'd1);
        tick();
        check("rw_wait_level", {27'd0, level}, 32'd5);
        check("rw_wait_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_valid", {31'd0, out_valid}, 32'd0);
        check("rw_level", {27'd0, level}, 32'd0);
        check("rw_rd_addr", {28'd0, rd_addr}, 32'd0);
        check("rw_ovf", {31'd0, overflow}, 32'd0);
        check("rw_data", {24'd0, out_data}, 32'd0);
        tick();
        check("rw_idle_rd_en", {31'd0, rd_en}, 32'd0);
        write1(8'h77);
        tick();
        check("rw_c2_rd_en", {31'd0, rd_en}, 32'd1);
        tick();
        check("rw_c3_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("rw_c4_valid", {31'd0, out_valid}, 32'd1);
        check("rw_c4_data", {24'd0, out_data}, 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
